// File: rtl/bf16_dot_accum_pkg.sv
// Shared bfloat16 field widths, constants and the accumulator FSM state type.
package bf16_dot_accum_pkg;

    // bfloat16 layout: {sign, exp[7:0], frac[6:0]}, hidden leading one implied
    localparam int unsigned BF16_DATA_W = 16;
    localparam int unsigned BF16_EXP_W  = 8;
    localparam int unsigned BF16_FRAC_W = 7;

    // Constants shared with the multiplier
    localparam int unsigned EXP_BIAS  = 127;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [15:0] BF16_ZERO = 16'h0000;

    // Accumulator control states
    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } acc_state_e;

endpackage

// File: rtl/bf16_add_comb.sv
// Combinational truncating float adder: align, add/subtract, normalise.
// Subnormal operands are flushed to zero; an all-ones exponent on either
// input, or a result exponent reaching all-ones, saturates to signed infinity.
module bf16_add_comb
    import bf16_dot_accum_pkg::*;
#(
    parameter int unsigned  EXP_WIDTH  = BF16_EXP_W,
    parameter int unsigned  FRAC_WIDTH = BF16_FRAC_W,
    localparam int unsigned DATA_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  ovf_o
);

    // Mantissa width including hidden one; exponent work width with headroom
    // for the carry increment and for going negative during normalisation.
    localparam int unsigned MW = FRAC_WIDTH + 1;
    localparam int unsigned XW = EXP_WIDTH + 2;

    localparam logic [EXP_WIDTH-1:0] EXP_ALL1    = '1;
    localparam logic [EXP_WIDTH-1:0] SHIFT_LIMIT = EXP_WIDTH'(FRAC_WIDTH + 2);
    localparam logic [XW-1:0]        XW_ONE      = XW'(1);
    localparam logic [XW-1:0]        XW_EXP_MAX  = XW'((1 << EXP_WIDTH) - 1);

    logic [EXP_WIDTH-1:0]  a_exp, b_exp;
    logic [DATA_WIDTH-2:0] a_key, b_key;
    logic                  a_big;

    logic                  l_sign, s_sign;
    logic [EXP_WIDTH-1:0]  l_exp, s_exp, exp_diff;
    logic [MW-1:0]         l_mant, s_mant, s_align;
    logic [MW:0]           mag_sum;
    logic [MW-1:0]         mag_dif;
    logic [XW-1:0]         lzc;
    logic [XW-1:0]         res_exp;
    logic [FRAC_WIDTH-1:0] res_frac;

    assign a_exp = a_i[DATA_WIDTH-2 -: EXP_WIDTH];
    assign b_exp = b_i[DATA_WIDTH-2 -: EXP_WIDTH];

    // Magnitude keys: a zero exponent means the operand is zero, whatever its fraction
    assign a_key = (a_exp == '0) ? '0 : a_i[DATA_WIDTH-2:0];
    assign b_key = (b_exp == '0) ? '0 : b_i[DATA_WIDTH-2:0];
    assign a_big = (a_key >= b_key);

    // Order operands by magnitude, align the smaller and form both sum and difference
    always_comb begin
        l_sign   = a_big ? a_i[DATA_WIDTH-1] : b_i[DATA_WIDTH-1];
        s_sign   = a_big ? b_i[DATA_WIDTH-1] : a_i[DATA_WIDTH-1];
        l_exp    = a_big ? a_exp : b_exp;
        s_exp    = a_big ? b_exp : a_exp;
        l_mant   = (l_exp == '0) ? '0
                 : {1'b1, (a_big ? a_i[FRAC_WIDTH-1:0] : b_i[FRAC_WIDTH-1:0])};
        s_mant   = (s_exp == '0) ? '0
                 : {1'b1, (a_big ? b_i[FRAC_WIDTH-1:0] : a_i[FRAC_WIDTH-1:0])};
        exp_diff = l_exp - s_exp;
        // Bits shifted out of the smaller operand are simply lost (truncation)
        s_align  = (exp_diff >= SHIFT_LIMIT) ? '0 : (s_mant >> exp_diff);
        mag_sum  = {1'b0, l_mant} + {1'b0, s_align};
        mag_dif  = l_mant - s_align;
    end

    // Leading-zero count of the difference for left normalisation
    always_comb begin
        logic found;
        found = 1'b0;
        lzc   = '0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found) begin
                if (mag_dif[i]) begin
                    found = 1'b1;
                end else begin
                    lzc = lzc + XW_ONE;
                end
            end
        end
    end

    // Normalise and pack, handling infinity, cancellation and underflow
    always_comb begin
        sum_o    = '0;
        ovf_o    = 1'b0;
        res_exp  = '0;
        res_frac = '0;
        if ((a_exp == EXP_ALL1) || (b_exp == EXP_ALL1)) begin
            sum_o = {l_sign, EXP_ALL1, {FRAC_WIDTH{1'b0}}};
            ovf_o = 1'b1;
        end else if (l_mant == '0) begin
            sum_o = '0;
        end else if (l_sign == s_sign) begin
            if (mag_sum[MW]) begin
                res_frac = mag_sum[FRAC_WIDTH:1];
                res_exp  = {2'b00, l_exp} + XW_ONE;
            end else begin
                res_frac = mag_sum[FRAC_WIDTH-1:0];
                res_exp  = {2'b00, l_exp};
            end
            if (res_exp >= XW_EXP_MAX) begin
                sum_o = {l_sign, EXP_ALL1, {FRAC_WIDTH{1'b0}}};
                ovf_o = 1'b1;
            end else begin
                sum_o = {l_sign, res_exp[EXP_WIDTH-1:0], res_frac};
            end
        end else if (mag_dif != '0) begin
            res_frac = FRAC_WIDTH'(mag_dif << lzc);
            res_exp  = {2'b00, l_exp} - lzc;
            // Underflow below the smallest normal flushes to +0 without overflow
            if (!res_exp[XW-1] && (res_exp != '0)) begin
                sum_o = {l_sign, res_exp[EXP_WIDTH-1:0], res_frac};
            end
        end
        // Exact cancellation falls through to the +0 default
    end

endmodule

// File: rtl/bf16_dot_accum.sv
// Streaming bfloat16 dot-product accumulator: sums one product per cycle over
// valid/ready and presents sum, beat count and sticky overflow on the result
// port once the last product of a vector has been accepted.
module bf16_dot_accum
    import bf16_dot_accum_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BF16_DATA_W,
    parameter int unsigned EXP_WIDTH  = BF16_EXP_W,
    parameter int unsigned FRAC_WIDTH = BF16_FRAC_W,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    input  logic [DATA_WIDTH-1:0] prod_data,
    input  logic                  prod_ovf,
    input  logic                  prod_last,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [CNT_W-1:0]      res_count,
    output logic                  res_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    acc_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] add_sum;
    logic                  add_ovf;
    logic                  accept;

    assign accept = prod_valid & prod_ready;

    bf16_add_comb #(
        .EXP_WIDTH  (EXP_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (prod_data),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // State and accumulator registers; reset drops any partial vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: accumulate until the last beat, then hold until the result is taken
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    state_d = prod_last ? StDone : StAccum;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: fold in accepted beats, clear on result handshake
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            acc_d = add_sum;
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            ovf_d = ovf_q | prod_ovf | add_ovf;
        end else if ((state_q == StDone) && res_ready) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Outputs: input stalls while a result is pending; result fields zero unless valid
    always_comb begin
        prod_ready = rst_n & (state_q != StDone);
        res_valid  = (state_q == StDone);
        res_data   = res_valid ? acc_q : '0;
        res_count  = res_valid ? cnt_q : '0;
        res_ovf    = res_valid & ovf_q;
    end

endmodule

// File: tb/tb_bf16_dot_accum.sv
// Self-checking bench for bf16_dot_accum: directed vector table, hand-written
// reset/stall sequences and random vectors checked against a behavioural model.
module tb_bf16_dot_accum;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        prod_valid = 1'b0;
    logic        prod_ready;
    logic [15:0] prod_data  = 16'h0;
    logic        prod_ovf   = 1'b0;
    logic        prod_last  = 1'b0;
    logic        res_valid;
    logic        res_ready  = 1'b0;
    logic [15:0] res_data;
    logic [7:0]  res_count;
    logic        res_ovf;

    int total = 0;
    int bad   = 0;

    logic [15:0] vb [0:299];
    logic        vo [0:299];
    int          vlen;

    typedef struct {
        logic [15:0] b0;
        logic [15:0] b1;
        logic        o0;
        logic        o1;
        int          n;
        int          hold;
        logic [15:0] ed;
        logic [7:0]  ec;
        logic        eo;
    } vec_t;

    vec_t tbl [10];

    bf16_dot_accum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .prod_ovf   (prod_ovf),
        .prod_last  (prod_last),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_count  (res_count),
        .res_ovf    (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference add built from the arithmetic rules: values as integer
    // mantissa/exponent pairs, normalised by repeated scaling.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            output logic ovf);
        int ka, kb, el, es, ml, ms, r, e;
        logic [15:0] big, sml;
        ovf = 1'b0;
        ka = (a[14:7] == 8'h00) ? 0 : int'(a[14:0]);
        kb = (b[14:7] == 8'h00) ? 0 : int'(b[14:0]);
        if (ka >= kb) begin big = a; sml = b; end
        else          begin big = b; sml = a; end
        if ((a[14:7] == 8'hFF) || (b[14:7] == 8'hFF)) begin
            ovf = 1'b1;
            return {big[15], 8'hFF, 7'h00};
        end
        if (big[14:7] == 8'h00) return 16'h0000;
        el = int'(big[14:7]);
        es = int'(sml[14:7]);
        ml = 128 + int'(big[6:0]);
        ms = (es == 0) ? 0 : 128 + int'(sml[6:0]);
        if (el - es >= 9) ms = 0;
        else              ms = ms >> (el - es);
        r = (big[15] == sml[15]) ? ml + ms : ml - ms;
        if (r == 0) return 16'h0000;
        e = el;
        while (r >= 256) begin r = r >> 1; e++; end
        while (r < 128)  begin r = r << 1; e--; end
        if (e < 1) return 16'h0000;
        if (e >= 255) begin
            ovf = 1'b1;
            return {big[15], 8'hFF, 7'h00};
        end
        return {big[15], e[7:0], r[6:0]};
    endfunction

    task automatic model_vec(output logic [15:0] d, output logic [7:0] c, output logic o);
        logic ao;
        int   cnt;
        d   = 16'h0000;
        o   = 1'b0;
        cnt = 0;
        for (int i = 0; i < vlen; i++) begin
            d = ref_add(d, vb[i], ao);
            o = o | vo[i] | ao;
            if (cnt < 255) cnt++;
        end
        c = 8'(cnt);
    endtask

    function automatic logic [15:0] rand_bf16();
        int          cls;
        logic [7:0]  e;
        logic        s;
        logic [6:0]  f;
        cls = int'($urandom_range(0, 19));
        s   = 1'($urandom_range(0, 1));
        f   = 7'($urandom);
        if (cls == 0)      e = 8'h00;
        else if (cls == 1) e = 8'hFF;
        else if (cls == 2) e = 8'($urandom_range(250, 254));
        else if (cls == 3) return s ? 16'hBF80 : 16'h3F80;
        else               e = 8'($urandom_range(118, 134));
        return {s, e, f};
    endfunction

    // Stream vb/vo, then check the result, stall `hold` cycles in DONE with a
    // beat offered, then hand the result off and check the return to idle.
    task automatic run_vec(input string tag, input int gap_max, input int hold,
                           input logic [15:0] ed, input logic [7:0] ec, input logic eo);
        int g;
        for (int i = 0; i < vlen; i++) begin
            @(negedge clk);
            if (gap_max > 0) begin
                g = int'($urandom_range(0, gap_max));
                prod_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            prod_valid = 1'b1;
            prod_data  = vb[i];
            prod_ovf   = vo[i];
            prod_last  = (i == vlen - 1);
            if (i == 0) chk({tag, "_rdy_in"}, 32'(prod_ready), 32'd1);
        end
        @(negedge clk);
        prod_valid = 1'b1;
        prod_data  = 16'h4000;
        prod_ovf   = 1'b1;
        prod_last  = 1'b1;
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_data"},  32'(res_data),  32'(ed));
        chk({tag, "_count"}, 32'(res_count), 32'(ec));
        chk({tag, "_ovf"},   32'(res_ovf),   32'(eo));
        chk({tag, "_rdy_done"}, 32'(prod_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(res_valid),  32'd1);
            chk({tag, "_hold_data"},  32'(res_data),   32'(ed));
            chk({tag, "_hold_count"}, 32'(res_count),  32'(ec));
            chk({tag, "_hold_ovf"},   32'(res_ovf),    32'(eo));
            chk({tag, "_hold_rdy"},   32'(prod_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready  = 1'b0;
        prod_valid = 1'b0;
        prod_ovf   = 1'b0;
        prod_last  = 1'b0;
        chk({tag, "_post_valid"}, 32'(res_valid),  32'd0);
        chk({tag, "_post_count"}, 32'(res_count),  32'd0);
        chk({tag, "_post_rdy"},   32'(prod_ready), 32'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rdy"},   32'(prod_ready), 32'd0);
        chk({tag, "_valid"}, 32'(res_valid),  32'd0);
        chk({tag, "_data"},  32'(res_data),   32'd0);
        chk({tag, "_count"}, 32'(res_count),  32'd0);
        chk({tag, "_ovf"},   32'(res_ovf),    32'd0);
    endtask

    initial begin
        logic [15:0] ed;
        logic [7:0]  ec;
        logic        eo;

        //          b0        b1        o0    o1    n  hold ed        ec     eo
        tbl[0] = '{16'h3F80, 16'h4000, 1'b0, 1'b0, 2, 0, 16'h4040, 8'd2, 1'b0};
        tbl[1] = '{16'h3F80, 16'hBF80, 1'b0, 1'b0, 2, 0, 16'h0000, 8'd2, 1'b0};
        tbl[2] = '{16'h7F00, 16'h7F00, 1'b0, 1'b0, 2, 0, 16'h7F80, 8'd2, 1'b1};
        tbl[3] = '{16'h3F80, 16'h0000, 1'b1, 1'b0, 1, 0, 16'h3F80, 8'd1, 1'b1};
        tbl[4] = '{16'h3F80, 16'h3B80, 1'b0, 1'b0, 2, 0, 16'h3F80, 8'd2, 1'b0};
        tbl[5] = '{16'h0001, 16'h3F80, 1'b0, 1'b0, 2, 0, 16'h3F80, 8'd2, 1'b0};
        tbl[6] = '{16'h3F80, 16'h4000, 1'b0, 1'b0, 2, 3, 16'h4040, 8'd2, 1'b0};
        tbl[7] = '{16'h4040, 16'hBF80, 1'b0, 1'b0, 2, 1, 16'h4000, 8'd2, 1'b0};
        tbl[8] = '{16'h00C0, 16'h8080, 1'b0, 1'b0, 2, 0, 16'h0000, 8'd2, 1'b0};
        tbl[9] = '{16'h7F80, 16'h3F80, 1'b0, 1'b0, 2, 0, 16'h7F80, 8'd2, 1'b1};

        // Reset state
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release_rdy", 32'(prod_ready), 32'd1);

        // Directed table
        for (int t = 0; t < 10; t++) begin
            vb[0] = tbl[t].b0;
            vb[1] = tbl[t].b1;
            vo[0] = tbl[t].o0;
            vo[1] = tbl[t].o1;
            vlen  = tbl[t].n;
            run_vec($sformatf("tbl%0d", t), 0, tbl[t].hold, tbl[t].ed, tbl[t].ec, tbl[t].eo);
        end

        // Count saturates: 260 ones, sum truncates at 256.0 once 1.0 aligns away
        vlen = 260;
        for (int i = 0; i < vlen; i++) begin
            vb[i] = 16'h3F80;
            vo[i] = 1'b0;
        end
        run_vec("sat", 0, 0, 16'h4380, 8'd255, 1'b0);

        // Reset mid-vector: two of four beats sent, then reset
        @(negedge clk);
        prod_valid = 1'b1;
        prod_data  = 16'h3F80;
        prod_last  = 1'b0;
        @(negedge clk);
        prod_data  = 16'h4000;
        @(negedge clk);
        prod_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk_zero_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        vlen  = 1;
        vb[0] = 16'h4000;
        vo[0] = 1'b0;
        run_vec("rst_mid_next", 0, 0, 16'h4000, 8'd1, 1'b0);

        // Reset while a result is pending drops it immediately
        @(negedge clk);
        prod_valid = 1'b1;
        prod_data  = 16'h3F80;
        prod_ovf   = 1'b1;
        prod_last  = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        prod_ovf   = 1'b0;
        prod_last  = 1'b0;
        chk("rst_done_pre_valid", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst_done");
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("rst_done_next", 0, 0, 16'h4000, 8'd1, 1'b0);

        // Random vectors against the model
        for (int v = 0; v < 60; v++) begin
            vlen = int'($urandom_range(1, 6));
            for (int i = 0; i < vlen; i++) begin
                vb[i] = rand_bf16();
                vo[i] = ($urandom_range(0, 15) == 0);
            end
            model_vec(ed, ec, eo);
            run_vec($sformatf("rnd%0d", v), 2, int'($urandom_range(0, 2)), ed, ec, eo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
